serial_adder_ctrl: RTL and testbench

//   Bit-serial adder sequencer. Adds two WIDTH-bit operands by time-multiplexing
//   one 1-bit full adder (instance of module adder) over WIDTH clock cycles.

---
 rtl/serial_adder_ctrl.sv | 158 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder sequencer. Adds two WIDTH-bit operands plus a carry-in by
//   running one shared 1-bit full adder (module adder) over WIDTH clock cycles,
//   LSB first, with the carry held in a flip-flop between cycles.
//
//   Ports
//     clk    in   1      rising-edge clock
//     reset  in   1      asynchronous, active-high; returns to IDLE, clears all
//     start  in   1      request, sampled only in IDLE
//     a, b   in   WIDTH  operands, latched on accepted start
//     cin    in   1      carry-in, latched on accepted start
//     busy   out  1      high while the serial addition is running
//     done   out  1      one-cycle pulse, sum/cout valid
//     sum    out  WIDTH  result, held until the next done
//     cout   out  1      final carry, held until the next done
// -----------------------------------------------------------------------------

// 1-bit full adder shared by the sequencer
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;

    adder u_adder (
        .a    (sha_q[0]),
        .b    (shb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Newest sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB
    assign acc_next = {fa_s, acc_q[WIDTH-1:1]};

    // Next-state and datapath update for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sha_d   = a;
                    shb_d   = b;
                    carry_d = cin;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sha_d   = {1'b0, sha_q[WIDTH-1:1]};
                shb_d   = {1'b0, shb_q[WIDTH-1:1]};
                acc_d   = acc_next;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = acc_next;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags are registered copies of the upcoming state
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sha_q   <= {WIDTH{1'b0}};
            shb_q   <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH=8). The reference is plain
//   arithmetic: {cout,sum} = a + b + cin, with busy expected for WIDTH cycles
//   after the accepting edge and done in the cycle after that.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp;
    int n_bad;

    // Result the outputs must currently hold (0 after reset)
    logic [WIDTH:0] held;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One operation; inject=1 re-pulses start (a=8'h11) in RUN cycle 3 and in DONE
    task automatic do_op(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                         input logic opc, input bit inject);
        logic [WIDTH:0] exp;
        exp = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, opc};
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; a = opa; b = opb; cin = opc;
        @(negedge clk);
        start = 1'b0;
        // operands may change freely once accepted
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        for (int i = 1; i <= WIDTH; i++) begin
            chk("run_busy", {31'd0, busy}, 32'd1);
            chk("run_done", {31'd0, done}, 32'd0);
            chk("run_hold", {23'd0, cout, sum}, {23'd0, held});
            if (inject && i == 3) begin
                start = 1'b1; a = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("sum", {24'd0, sum}, {24'd0, exp[WIDTH-1:0]});
        chk("cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
        held = exp;
        start = inject;
        @(negedge clk);
        start = 1'b0;
        chk("post_done", {31'd0, done}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_hold", {23'd0, cout, sum}, {23'd0, held});
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; held = '0;
        reset = 1'b1; start = 1'b1; a = '0; b = '0; cin = 1'b0;

        // Reset with start held high
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_norun", {31'd0, busy}, 32'd0);

        // Directed cases
        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        do_op(8'h7F, 8'h80, 1'b0, 1'b0);
        do_op(8'h3C, 8'h42, 1'b1, 1'b1);

        // Reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sum", {24'd0, sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        held = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            @(negedge clk);
            chk("mid_no_done", {30'd0, busy, done}, 32'd0);
        end
        do_op(8'h12, 8'h34, 1'b1, 1'b0);

        // Randomized operations, some with ignored start re-pulses
        for (int k = 0; k < 30; k++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
